// File: rtl/symbol_frame_arbiter.sv
// symbol_frame_arbiter: shares one symbol_encoder between two symbol sources.
// Whole frames are granted round-robin. SYNC symbols (FRP=111) go out while idle,
// during the preamble and after an aborted frame, so every frame starts from pos_x.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   reqN_valid/frp/last/ready     symbol stream from requester N (N=0,1), {Flip,Rotate,Polarity}
//   ss_Flip/ss_Rotate/ss_Polarity registered encoder command
//   grant                         one-hot owner of the current frame, 00 when none
//   frame_done                    one-cycle pulse issued with a frame's last symbol
//   underrun, bad_code            sticky error flags, cleared only by reset
// Optional feature, macro STATE_MIRROR_EN:
//   enc_state                     encoder wire_state {axis[1:0], neg}
//   mirror_err                    sticky, the local encoder model disagreed with enc_state
module symbol_frame_arbiter #(
    parameter int unsigned PRE_LEN = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_frp,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_frp,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       ss_Flip,
    output logic       ss_Rotate,
    output logic       ss_Polarity,
    output logic [1:0] grant,
    output logic       frame_done,
    output logic       underrun,
    output logic       bad_code
`ifdef STATE_MIRROR_EN
    ,
    input  logic [2:0] enc_state,
    output logic       mirror_err
`endif
);

    localparam logic [2:0] SYNC = 3'b111;

    typedef enum logic [1:0] {IDLE, PRE, XFER, ABORT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ss_q;
    logic             rr_ptr;      // 0: req0 wins a tie, 1: req1 wins a tie

    // Symbol stream of the current owner
    logic       sel_valid;
    logic       sel_last;
    logic [2:0] sel_frp;
    logic       sel_bad;
    logic       pick1;

    assign sel_valid = grant[1] ? req1_valid : req0_valid;
    assign sel_last  = grant[1] ? req1_last  : req0_last;
    assign sel_frp   = grant[1] ? req1_frp   : req0_frp;
    assign sel_bad   = sel_frp[2] & (sel_frp[1] | sel_frp[0]);
    assign pick1     = req1_valid & (~req0_valid | rr_ptr);

    assign {ss_Flip, ss_Rotate, ss_Polarity} = ss_q;

    // Frame FSM with registered encoder command, grant, ready and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ss_q       <= SYNC;
            grant      <= 2'b00;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            bad_code   <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            ss_q       <= SYNC;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant <= pick1 ? 2'b10 : 2'b01;
                        cnt   <= CNT_W'(PRE_LEN - 1);
                        state <= PRE;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        req0_ready <= grant[0];
                        req1_ready <= grant[1];
                        state      <= XFER;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                XFER: begin
                    if (sel_valid) begin
                        // Codes 101..111 are not payload; substitute SYNC
                        if (sel_bad) begin
                            bad_code <= 1'b1;
                        end else begin
                            ss_q <= sel_frp;
                        end
                        if (sel_last) begin
                            frame_done <= 1'b1;
                            rr_ptr     <= grant[0];
                            grant      <= 2'b00;
                            req0_ready <= 1'b0;
                            req1_ready <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        underrun <= 1'b1;
                        state    <= ABORT;
                    end
                end
                ABORT: begin
                    // Drain the rest of the frame while holding the encoder at SYNC
                    if (sel_valid && sel_last) begin
                        frame_done <= 1'b1;
                        rr_ptr     <= grant[0];
                        grant      <= 2'b00;
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STATE_MIRROR_EN
    logic [2:0] model_q;

    // Encoder transition on {axis[1:0], neg}; x=00, y=01, z=10
    function automatic logic [2:0] enc_next(input logic [2:0] st, input logic [2:0] code);
        logic [1:0] axis;
        logic       neg;
        axis = st[2:1];
        neg  = st[0];
        if (code[2]) begin
            if (code[1:0] == 2'b00) begin
                enc_next = {axis, ~neg};
            end else begin
                enc_next = 3'b000;
            end
        end else begin
            if (code[1]) begin
                case (axis)
                    2'b00:   axis = 2'b01;
                    2'b01:   axis = 2'b10;
                    default: axis = 2'b00;
                endcase
            end else begin
                case (axis)
                    2'b00:   axis = 2'b10;
                    2'b10:   axis = 2'b01;
                    default: axis = 2'b00;
                endcase
            end
            enc_next = {axis, neg ^ code[0]};
        end
    endfunction

    // Model tracks the encoder, which applies ss_* one clock after it is driven
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q    <= 3'b000;
            mirror_err <= 1'b0;
        end else begin
            model_q <= enc_next(model_q, ss_q);
            if (model_q != enc_state) begin
                mirror_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_symbol_frame_arbiter.sv
// Self-checking bench for symbol_frame_arbiter: randomized frame drivers push the
// symbols they issue into per-requester queues; a negedge monitor runs a
// frame-level arbitration model and compares every output each cycle.
module tb_symbol_frame_arbiter;

    localparam int unsigned PRE_LEN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [2:0] f0 = 3'd0, f1 = 3'd0;
    logic       r0, r1, sf, sr, sp, fd, un, bc;
    logic [1:0] gr;
`ifdef STATE_MIRROR_EN
    logic [2:0] enc_m;
    logic [2:0] enc_state;
    logic       corrupt = 1'b0;
    logic       merr;
`endif

    symbol_frame_arbiter #(.PRE_LEN(PRE_LEN), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_frp(f0), .req0_last(l0), .req0_ready(r0),
        .req1_valid(v1), .req1_frp(f1), .req1_last(l1), .req1_ready(r1),
        .ss_Flip(sf), .ss_Rotate(sr), .ss_Polarity(sp),
        .grant(gr), .frame_done(fd), .underrun(un), .bad_code(bc)
`ifdef STATE_MIRROR_EN
        , .enc_state(enc_state), .mirror_err(merr)
`endif
    );

    typedef struct packed {
        logic [2:0] frp;
        logic       last;
    } sym_t;

    sym_t q0[$];
    sym_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ss"},         32'({sf, sr, sp}), 32'd7);
        chk({tag, " grant"},      32'(gr), 32'd0);
        chk({tag, " ready0"},     32'(r0), 32'd0);
        chk({tag, " ready1"},     32'(r1), 32'd0);
        chk({tag, " frame_done"}, 32'(fd), 32'd0);
        chk({tag, " underrun"},   32'(un), 32'd0);
        chk({tag, " bad_code"},   32'(bc), 32'd0);
    endtask

    // ---------------- monitor / reference model ----------------
    logic [2:0] e_ss;
    logic       e_done, e_un, e_bad;
    logic [1:0] e_grant, e_rdy;
    bit         m_idle, m_active, m_ab, m_ptr, m_owner, in_x, ov;
    int         m_start, cyc;
    sym_t       s_pop;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_ss = 3'd7; e_done = 1'b0; e_un = 1'b0; e_bad = 1'b0;
            e_grant = 2'b00; e_rdy = 2'b00;
            m_idle = 1'b1; m_active = 1'b0; m_ab = 1'b0; m_ptr = 1'b0; m_owner = 1'b0;
            m_start = 0; cyc = 0;
        end else begin
            chk("ss",         32'({sf, sr, sp}), 32'(e_ss));
            chk("frame_done", 32'(fd), 32'(e_done));
            chk("grant",      32'(gr), 32'(e_grant));
            chk("ready0",     32'(r0), 32'(e_rdy[0]));
            chk("ready1",     32'(r1), 32'(e_rdy[1]));
            chk("underrun",   32'(un), 32'(e_un));
            chk("bad_code",   32'(bc), 32'(e_bad));

            e_ss   = 3'd7;
            e_done = 1'b0;
            in_x   = m_active && (cyc >= m_start);
            if (m_idle) begin
                if (v0 || v1) begin
                    m_owner  = (v0 && v1) ? m_ptr : v1;
                    m_idle   = 1'b0;
                    m_active = 1'b1;
                    m_ab     = 1'b0;
                    m_start  = cyc + int'(PRE_LEN) + 1;
                    e_grant  = m_owner ? 2'b10 : 2'b01;
                end
            end else if (in_x) begin
                ov = m_owner ? v1 : v0;
                if (ov) begin
                    if ((m_owner ? q1.size() : q0.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: accept by req%0d with no issued symbol at %0t", m_owner, $time);
                    end else begin
                        if (m_owner) s_pop = q1.pop_front();
                        else         s_pop = q0.pop_front();
                        acc_cnt++;
                        if (!m_ab) begin
                            if (s_pop.frp >= 3'd5) e_bad = 1'b1;
                            else                   e_ss  = s_pop.frp;
                        end
                        if (s_pop.last) begin
                            e_done   = 1'b1;
                            m_active = 1'b0;
                            m_idle   = 1'b1;
                            e_grant  = 2'b00;
                            m_ptr    = ~m_owner;
                        end
                    end
                end else if (!m_ab) begin
                    m_ab = 1'b1;
                    e_un = 1'b1;
                end
            end
            e_rdy = 2'b00;
            if (m_active && (cyc + 1 >= m_start)) e_rdy[m_owner] = 1'b1;
            cyc++;
        end
    end

`ifdef STATE_MIRROR_EN
    // Encoder behaviour: x=0, y=1, z=2 with arithmetic rotation
    function automatic logic [2:0] tb_enc(input logic [2:0] st, input logic [2:0] c);
        int   ax;
        logic n;
        ax = int'(st[2:1]);
        n  = st[0];
        if (c >= 3'd5) return 3'b000;
        if (c == 3'd4) return {st[2:1], ~n};
        if (c[1]) ax = (ax + 1) % 3;
        else      ax = (ax + 2) % 3;
        return {2'(ax), n ^ c[0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) enc_m <= 3'b000;
        else        enc_m <= tb_enc(enc_m, {sf, sr, sp});
    end
    assign enc_state = enc_m ^ {2'b00, corrupt};
`endif

    // ---------------- drivers ----------------
    task automatic set_req(input int r, input logic v, input logic [2:0] f, input logic l);
        if (r == 0) begin v0 = v; f0 = f; l0 = l; end
        else        begin v1 = v; f1 = f; l1 = l; end
    endtask

    // drop_mode: 0 never, 1 random, 2 after the first symbol
    task automatic send_frame(input int r, input int n, input logic [2:0] s [8], input int drop_mode);
        bit   dropped;
        int   to;
        sym_t e;
        dropped = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.frp  = s[k];
            e.last = (k == n - 1);
            set_req(r, 1'b1, s[k], e.last);
            if (r == 0) q0.push_back(e);
            else        q1.push_back(e);
            to = 0;
            forever begin
                @(negedge clk);
                if ((r == 0) ? r0 : r1) break;
                to++;
                if (to > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout req%0d: waited %0d cycles, limit 400", r, to);
                    set_req(r, 1'b0, 3'd0, 1'b0);
                    return;
                end
            end
            @(posedge clk); #1;
            if (!dropped && k < n - 1 &&
                ((drop_mode == 2 && k == 0) || (drop_mode == 1 && $urandom_range(0, 3) == 0))) begin
                dropped = 1'b1;
                set_req(r, 1'b0, s[k + 1], 1'b0);
                @(posedge clk); #1;
            end
        end
        set_req(r, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic drv(input int r, input int nf, input bit bad_ok, input int drop_mode);
        logic [2:0] s [8];
        int         len;
        for (int f = 0; f < nf; f++) begin
            if (f > 0) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            len = $urandom_range(1, 5);
            for (int k = 0; k < 8; k++) begin
                if (bad_ok && $urandom_range(0, 9) == 0) s[k] = 3'($urandom_range(5, 7));
                else                                     s[k] = 3'($urandom_range(0, 4));
            end
            send_frame(r, len, s, drop_mode);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0] s [8];
        sym_t       e;
        int         start_acc;
        int         to;

        #1 rst_n = 1'b0;
        #1 chk_reset("power_on_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // req0: 010, 000, 100
        s = '{3'd2, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send_frame(0, 3, s, 0);
        repeat (3) begin @(posedge clk); #1; end

        // req0 payload 110 inside a frame
        s = '{3'd1, 3'd6, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send_frame(0, 3, s, 0);

        // req1 drops valid after its first symbol
        s = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send_frame(1, 3, s, 2);
        repeat (2) begin @(posedge clk); #1; end

        // both requesters, random frames, bad codes and underruns
        fork
            drv(0, 15, 1'b1, 1);
            drv(1, 15, 1'b1, 1);
        join
        repeat (4) begin @(posedge clk); #1; end

        // reset in the middle of a transfer
        e.frp  = 3'd3;
        e.last = 1'b0;
        set_req(0, 1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 12; k++) q0.push_back(e);
        start_acc = acc_cnt;
        to = 0;
        while (acc_cnt < start_acc + 2 && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (acc_cnt < start_acc + 2) begin
            checks++;
            errors++;
            $display("FAIL mid_xfer_wait: accepted %0d symbols, need 2", acc_cnt - start_acc);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset("mid_xfer_reset");
        set_req(0, 1'b0, 3'd0, 1'b0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // both valid right after reset: req0 must win first
        fork
            drv(0, 3, 1'b0, 0);
            drv(1, 3, 1'b0, 0);
        join
        repeat (6) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

`ifdef STATE_MIRROR_EN
        chk("mirror_err_clean", 32'(merr), 32'd0);
        @(posedge clk); #1 corrupt = 1'b1;
        @(posedge clk); #1 corrupt = 1'b0;
        @(negedge clk);
        chk("mirror_err_set", 32'(merr), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
